// File: rtl/fht_twiddle_gen.sv
// FHT twiddle source: quarter-wave cosine ROM, symmetry fold, 2-stage pipe.
// Define FHT_TW_READY_EN to add the iREADY backpressure port.
module fht_twiddle_gen #(
  parameter int A_BIT = 4,
  parameter int W_BIT = 12
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic [A_BIT-1:0] iSTAGE,
`ifdef FHT_TW_READY_EN
  input  logic             iREADY,
`endif
  output logic             oVALID,
  output logic [W_BIT-1:0] oCOS,
  output logic [W_BIT-1:0] oSIN,
  output logic [A_BIT-2:0] oBF_IDX,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR
);

  localparam int N = 1 << A_BIT;
  localparam real ONE = real'(1 << (W_BIT - 2));
  localparam logic [A_BIT-1:0] QTR  = A_BIT'(N / 4);
  localparam logic [A_BIT-1:0] HALF = A_BIT'(N / 2);
  localparam logic [A_BIT-1:0] SMAX = A_BIT'(A_BIT - 1);
  localparam logic [A_BIT-2:0] BLAST = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Elaboration-time cosine via Taylor series; entries past N/4 are unused.
  function automatic logic [W_BIT-1:0] q_val(input int i);
    real x, t, acc;
    if (i > N / 4) return '0;
    x   = 2.0 * 3.14159265358979323846 * $itor(i) / $itor(N);
    t   = 1.0;
    acc = 1.0;
    for (int k = 1; k < 14; k++) begin
      t   = -t * x * x / $itor((2 * k - 1) * (2 * k));
      acc = acc + t;
    end
    return W_BIT'($rtoi(acc * ONE + 0.5));
  endfunction

  logic [W_BIT-1:0] rom [N];
  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom[g] = q_val(g);
  end

  logic [1:0]       st_q, st_d;
  logic [A_BIT-1:0] s_q;
  logic [A_BIT-2:0] b_q;
  logic             v1_q, neg1_q;
  logic [A_BIT-2:0] b1_q;
  logic [W_BIT-1:0] cos1_q, sin1_q;
  logic             v2_q;
  logic [A_BIT-2:0] b2_q;
  logic [W_BIT-1:0] cos2_q, sin2_q;
  logic             err_q;

  logic             rdy, adv, issue, bad, last_hs;
  logic [A_BIT-1:0] mask, k, j, caddr, saddr;
  logic             cneg;

`ifdef FHT_TW_READY_EN
  assign rdy = iREADY;
`else
  assign rdy = 1'b1;
`endif

  always_comb begin
    adv     = !v2_q || rdy;
    issue   = (st_q == S_RUN) && adv;
    bad     = iSTAGE > SMAX;
    last_hs = (st_q == S_DRAIN) && v2_q && rdy && (b2_q == BLAST);
    mask    = ~({A_BIT{1'b1}} << s_q);
    k       = {1'b0, b_q} & mask;
    j       = k << (SMAX - s_q);
    cneg    = j > QTR;
    caddr   = cneg ? (HALF - j) : j;
    saddr   = cneg ? (j - QTR) : (QTR - j);
  end

  always_comb begin
    st_d = st_q;
    unique case (1'b1)
      st_q == S_IDLE:  if (iSTART && !bad) st_d = S_RUN;
      st_q == S_RUN:   if (adv && b_q == BLAST) st_d = S_DRAIN;
      st_q == S_DRAIN: if (last_hs) st_d = S_IDLE;
      default:         st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      st_q   <= S_IDLE;
      s_q    <= '0;
      b_q    <= '0;
      v1_q   <= 1'b0;
      neg1_q <= 1'b0;
      b1_q   <= '0;
      cos1_q <= '0;
      sin1_q <= '0;
      v2_q   <= 1'b0;
      b2_q   <= '0;
      cos2_q <= '0;
      sin2_q <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      err_q <= (st_q == S_IDLE) && iSTART && bad;
      if (st_q == S_IDLE && iSTART && !bad) begin
        s_q <= iSTAGE;
        b_q <= '0;
      end else if (issue) begin
        b_q <= b_q + 1'b1;
      end
      if (adv) begin
        v1_q <= issue;
        if (issue) begin
          b1_q   <= b_q;
          neg1_q <= cneg;
          cos1_q <= rom[caddr];
          sin1_q <= rom[saddr];
        end
        v2_q <= v1_q;
        if (v1_q) begin
          b2_q   <= b1_q;
          cos2_q <= neg1_q ? -cos1_q : cos1_q;
          sin2_q <= sin1_q;
        end
      end
    end
  end

  assign oVALID  = v2_q;
  assign oCOS    = cos2_q;
  assign oSIN    = sin2_q;
  assign oBF_IDX = b2_q;
  assign oBUSY   = st_q != S_IDLE;
  assign oDONE   = last_hs;
  assign oERR    = err_q;

endmodule

// File: tb/tb_fht_twiddle_gen.sv
// Bench for fht_twiddle_gen: trig model queue plus literal twiddle pins.
module tb_fht_twiddle_gen;

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b0;
  logic        iSTART = 1'b0;
  logic [3:0]  iSTAGE = '0;
  logic        iREADY = 1'b1;
  logic        oVALID;
  logic [11:0] oCOS, oSIN;
  logic [2:0]  oBF_IDX;
  logic        oBUSY, oDONE, oERR;

  fht_twiddle_gen #(.A_BIT(4), .W_BIT(12)) dut (
    .iCLK(iCLK),
    .iRESET(iRESET),
    .iSTART(iSTART),
    .iSTAGE(iSTAGE),
`ifdef FHT_TW_READY_EN
    .iREADY(iREADY),
`endif
    .oVALID(oVALID),
    .oCOS(oCOS),
    .oSIN(oSIN),
    .oBF_IDX(oBF_IDX),
    .oBUSY(oBUSY),
    .oDONE(oDONE),
    .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int c;
    int s;
    int b;
    bit last;
  } tup_t;

  tup_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   cap_c [8];
  int   cap_s [8];

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  task automatic push_stage(input int s);
    tup_t t;
    int   kk, jj;
    real  a;
    for (int b = 0; b < 8; b++) begin
      kk = b % (1 << s);
      jj = kk << (3 - s);
      a  = 2.0 * 3.14159265358979323846 * jj / 16.0;
      t.c = rnd(1024.0 * $cos(a));
      t.s = rnd(1024.0 * $sin(a));
      t.b = b;
      t.last = (b == 7);
      exp_q.push_back(t);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge iCLK) begin
    tup_t e;
    bit   hs;
    if (iRESET) begin
      if (oVALID) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid idx=%0d", oBF_IDX);
        end else begin
          e  = exp_q[0];
          hs = iREADY;
`ifndef FHT_TW_READY_EN
          hs = 1'b1;
`endif
          checks++;
          if (int'($signed(oCOS)) != e.c || int'($signed(oSIN)) != e.s ||
              int'(oBF_IDX) != e.b) begin
            failures++;
            $display("FAIL tuple actual=(%0d,%0d,b%0d) required=(%0d,%0d,b%0d)",
                     $signed(oCOS), $signed(oSIN), oBF_IDX, e.c, e.s, e.b);
          end
          checks++;
          if (oDONE != (hs && e.last)) begin
            failures++;
            $display("FAIL done_flag actual=%0d required=%0d", oDONE, hs && e.last);
          end
          if (hs) begin
            cap_c[e.b] = int'($signed(oCOS));
            cap_s[e.b] = int'($signed(oSIN));
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end else begin
        checks++;
        if (oDONE) begin
          failures++;
          $display("FAIL done_without_valid actual=1 required=0");
        end
      end
      if (oDONE && oERR) begin
        checks++;
        failures++;
        $display("FAIL done_err_overlap actual=1 required=0");
      end
      if (oDONE) done_cnt++;
    end
  end

  task automatic wait_done(input int d0, input int h0, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge iCLK); #1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_busy_fall"}, int'(oBUSY), 0);
    chk({tag, "_hs_count"}, hs_cnt - h0, 8);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  task automatic run_stage(input int s, input bit intr, input string tag);
    int d0 = done_cnt;
    int h0 = hs_cnt;
    push_stage(s);
    iSTART = 1'b1;
    iSTAGE = 4'(s);
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    chk({tag, "_busy_rise"}, int'(oBUSY), 1);
    chk({tag, "_lat_e0"}, int'(oVALID), 0);
    @(posedge iCLK); #1;
    chk({tag, "_lat_e1"}, int'(oVALID), 0);
    if (intr) begin
      iSTART = 1'b1;
      iSTAGE = 4'd0;
    end
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    chk({tag, "_lat_e2"}, int'(oVALID), 1);
    wait_done(d0, h0, tag);
  endtask

  initial begin
    int d0, h0;
    #1;
    chk("rst_valid", int'(oVALID), 0);
    chk("rst_busy", int'(oBUSY), 0);
    chk("rst_cos", int'(oCOS), 0);
    repeat (3) @(posedge iCLK);
    #1 iRESET = 1'b1;
    @(posedge iCLK); #1;

    run_stage(0, 1'b0, "s0");
    chk("s0_b0_cos", cap_c[0], 1024);
    chk("s0_b0_sin", cap_s[0], 0);
    chk("s0_b7_cos", cap_c[7], 1024);
    chk("s0_b7_sin", cap_s[7], 0);

    run_stage(3, 1'b1, "s3");
    chk("s3_b0_cos", cap_c[0], 1024);
    chk("s3_b0_sin", cap_s[0], 0);
    chk("s3_b2_cos", cap_c[2], 724);
    chk("s3_b2_sin", cap_s[2], 724);
    chk("s3_b4_cos", cap_c[4], 0);
    chk("s3_b4_sin", cap_s[4], 1024);
    chk("s3_b5_cos", cap_c[5], -392);
    chk("s3_b5_sin", cap_s[5], 946);
    chk("s3_b6_cos", cap_c[6], -724);
    chk("s3_b6_sin", cap_s[6], 724);
    chk("s3_b7_cos", cap_c[7], -946);
    chk("s3_b7_sin", cap_s[7], 392);

    run_stage(1, 1'b0, "s1");
    chk("s1_b2_cos", cap_c[2], 1024);
    chk("s1_b2_sin", cap_s[2], 0);
    chk("s1_b3_cos", cap_c[3], 0);
    chk("s1_b3_sin", cap_s[3], 1024);

    iSTART = 1'b1;
    iSTAGE = 4'd4;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    chk("err_pulse", int'(oERR), 1);
    chk("err_idle", int'(oBUSY), 0);
    @(posedge iCLK); #1;
    chk("err_clear", int'(oERR), 0);
    chk("err_no_valid", int'(oVALID), 0);
    chk("err_still_idle", int'(oBUSY), 0);

`ifdef FHT_TW_READY_EN
    begin
      bit found = 1'b0;
      d0 = done_cnt;
      h0 = hs_cnt;
      push_stage(2);
      iSTART = 1'b1;
      iSTAGE = 4'd2;
      @(posedge iCLK); #1;
      iSTART = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (oVALID && oBF_IDX == 3'd3) begin
          found = 1'b1;
          break;
        end
        @(posedge iCLK); #1;
      end
      chk("stall_reach_b3", int'(found), 1);
      iREADY = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(posedge iCLK); #1;
        chk("stall_hold_valid", int'(oVALID), 1);
        chk("stall_hold_idx", int'(oBF_IDX), 3);
      end
      iREADY = 1'b1;
      wait_done(d0, h0, "stall");
    end
`endif

    d0 = done_cnt;
    push_stage(2);
    iSTART = 1'b1;
    iSTAGE = 4'd2;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    repeat (4) @(posedge iCLK);
    #3 iRESET = 1'b0;
    #1;
    chk("mrst_valid", int'(oVALID), 0);
    chk("mrst_cos", int'(oCOS), 0);
    chk("mrst_sin", int'(oSIN), 0);
    chk("mrst_idx", int'(oBF_IDX), 0);
    chk("mrst_busy", int'(oBUSY), 0);
    chk("mrst_done", int'(oDONE), 0);
    exp_q.delete();
    @(posedge iCLK); #1;
    iRESET = 1'b1;
    repeat (12) @(posedge iCLK);
    #1;
    chk("mrst_no_done", done_cnt - d0, 0);
    chk("mrst_idle", int'(oBUSY), 0);

    run_stage(3, 1'b0, "post");
    chk("post_b5_cos", cap_c[5], -392);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
